// File: rtl/sprite_compositor.sv
// sprite_compositor: per-pixel stage that overlays one 32x32 animated, optionally
// mirrored sprite on the background colour. The sprite position is double-buffered
// and only takes effect at frame start, so the sprite never tears.
module sprite_compositor #(
    parameter int unsigned SPR_W    = 32,
    parameter int unsigned SPR_H    = 32,
    parameter logic [11:0] KEY      = 12'hF0F,
    parameter int unsigned ANIM_DIV = 8,
    parameter int unsigned H_ACT    = 640,
    parameter int unsigned V_ACT    = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  logic [11:0] bg_color,
    input  logic [9:0]  obj_x,
    input  logic [8:0]  obj_y,
    input  logic        obj_mirror,
    input  logic        pos_wr,
    output logic [10:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [11:0] color,
    output logic        color_valid,
    output logic        frame_tick
);

    localparam int unsigned CW = $clog2(SPR_W);
    localparam int unsigned RW = $clog2(SPR_H);
    localparam int unsigned AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    // Pending (written any time) and active (frame-aligned) sprite position
    logic [9:0]    pend_x;
    logic [8:0]    pend_y;
    logic          pend_mirror;
    logic          pend_flag;
    logic [9:0]    act_x;
    logic [8:0]    act_y;
    logic          act_mirror;

    // Animation phase
    logic [AW-1:0] anim_cnt;
    logic          anim_sel;

    // Combinational hit test / address
    logic          frame_start;
    logic          hit;
    logic [10:0]   x_end;
    logic [9:0]    y_end;
    logic [CW-1:0] dx;
    logic [RW-1:0] dy;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Stage-1 pipeline registers
    logic          hit1;
    logic          act1;
    logic [11:0]   bg1;

    // Frame start is only recognised on a pixel enable
    assign frame_start = pix_ce && (x == 10'd0) && (y == 9'd0);

    // Hit test and sprite-relative address from the registered active position
    always_comb begin
        // One extra bit on the end coordinates so a sprite past the right or
        // bottom edge is clipped instead of wrapping back to column/row 0.
        x_end = {1'b0, act_x} + 11'(SPR_W);
        y_end = {1'b0, act_y} + 10'(SPR_H);
        hit   = (x >= act_x) && ({1'b0, x} < x_end) &&
                (y >= act_y) && ({1'b0, y} < y_end);
        // Low bits of the difference equal the difference of the low bits
        dx    = CW'(x) - CW'(act_x);
        dy    = RW'(y) - RW'(act_y);
        row   = dy;
        // SPR_W is a power of two, so SPR_W-1-col is a bitwise inversion
        col   = act_mirror ? ~dx : dx;
    end

    // Pending position capture; any clock, last write before frame start wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_x      <= 10'd0;
            pend_y      <= 9'd0;
            pend_mirror <= 1'b0;
            pend_flag   <= 1'b0;
        end else begin
            if (pos_wr) begin
                pend_x      <= obj_x;
                pend_y      <= obj_y;
                pend_mirror <= obj_mirror;
            end
            // A write coinciding with frame start stays pending for the next frame
            if (pos_wr) begin
                pend_flag <= 1'b1;
            end else if (frame_start) begin
                pend_flag <= 1'b0;
            end
        end
    end

    // Frame-start bookkeeping: tick pulse, active position swap, animation phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_tick <= 1'b0;
            act_x      <= 10'h3FF;
            act_y      <= 9'd0;
            act_mirror <= 1'b0;
            anim_cnt   <= '0;
            anim_sel   <= 1'b0;
        end else begin
            frame_tick <= frame_start;
            if (frame_start) begin
                if (pend_flag) begin
                    act_x      <= pend_x;
                    act_y      <= pend_y;
                    act_mirror <= pend_mirror;
                end
                if (anim_cnt == AW'(ANIM_DIV - 1)) begin
                    anim_cnt <= '0;
                    anim_sel <= ~anim_sel;
                end else begin
                    anim_cnt <= anim_cnt + 1'b1;
                end
            end
        end
    end

    // Stage 1: issue the ROM address and carry per-pixel context alongside it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr <= 11'd0;
            hit1     <= 1'b0;
            act1     <= 1'b0;
            bg1      <= 12'd0;
        end else if (pix_ce) begin
            if (hit) begin
                rom_addr <= {anim_sel, row, col};
            end
            hit1 <= hit;
            act1 <= (x < 10'(H_ACT)) && (y < 9'(V_ACT));
            bg1  <= bg_color;
        end
    end

    // Stage 2: choose sprite, background or blank using the returned ROM word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            color       <= 12'd0;
            color_valid <= 1'b0;
        end else if (pix_ce) begin
            if (!act1) begin
                color <= 12'd0;
            end else if (hit1 && (rom_data != KEY)) begin
                color <= rom_data;
            end else begin
                color <= bg1;
            end
            color_valid <= act1;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed self-checking bench for sprite_compositor.
module tb_sprite_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_ce;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] bg_color;
    logic [9:0]  obj_x;
    logic [8:0]  obj_y;
    logic        obj_mirror;
    logic        pos_wr;
    logic [10:0] rom_addr;
    logic [11:0] rom_data;
    logic [11:0] color;
    logic        color_valid;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;
    int tick_cnt = 0;

    logic        rom_force     = 1'b0;
    logic [11:0] rom_force_val = 12'h000;

    sprite_compositor dut (
        .clk        (clk),
        .rst        (rst),
        .pix_ce     (pix_ce),
        .x          (x),
        .y          (y),
        .bg_color   (bg_color),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_mirror (obj_mirror),
        .pos_wr     (pos_wr),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .color      (color),
        .color_valid(color_valid),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: each word is its own address (bit 11 clear, never the key)
    always @(posedge clk) rom_data <= rom_force ? rom_force_val : {1'b0, rom_addr};

    // Count clocks with frame_tick high; a stretched pulse would over-count
    always @(posedge clk) if (frame_tick) tick_cnt <= tick_cnt + 1;

    // One pixel: inputs at a falling edge, pix_ce for one clock, then three idle clocks
    task automatic present(input logic [9:0] px, input logic [8:0] py, input logic [11:0] bg);
        @(negedge clk);
        x        = px;
        y        = py;
        bg_color = bg;
        pix_ce   = 1'b1;
        @(negedge clk);
        pix_ce = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic write_pos(input logic [9:0] ox, input logic [8:0] oy, input logic m);
        @(negedge clk);
        obj_x      = ox;
        obj_y      = oy;
        obj_mirror = m;
        pos_wr     = 1'b1;
        @(negedge clk);
        pos_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; pix_ce = 1'b0; x = '0; y = '0; bg_color = '0;
        obj_x = '0; obj_y = '0; obj_mirror = 1'b0; pos_wr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (color !== 12'h000 || color_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: color=%h valid=%b want 000/0", color, color_valid);
        end
        checks++;
        if (rom_addr !== 11'h000 || frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_addr_tick: rom_addr=%h tick=%b want 000/0", rom_addr, frame_tick);
        end
        @(negedge clk); rst = 1'b1;
        present(10'd7, 9'd7, 12'h321);
        present(10'd8, 9'd7, 12'h321);
        checks++;
        if (color !== 12'h321 || color_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_bg: color=%h valid=%b want 321/1", color, color_valid);
        end
        // Asynchronous reset in the middle of a line, away from any clock edge
        #3 rst = 1'b0;
        #1;
        checks++;
        if (color !== 12'h000 || color_valid !== 1'b0 || rom_addr !== 11'h000) begin
            failures++;
            $display("FAIL async_reset: color=%h valid=%b addr=%h want 000/0/000",
                     color, color_valid, rom_addr);
        end
        @(negedge clk); rst = 1'b1;
        present(10'd5, 9'd5, 12'hABC);
        checks++;
        if (color !== 12'h000 || color_valid !== 1'b0) begin
            failures++;
            $display("FAIL restart_1ce: color=%h valid=%b want 000/0", color, color_valid);
        end
        present(10'd6, 9'd5, 12'hABC);
        checks++;
        if (color !== 12'hABC || color_valid !== 1'b1) begin
            failures++;
            $display("FAIL restart_2ce: color=%h valid=%b want ABC/1", color, color_valid);
        end
    endtask

    task automatic test_frame_aligned();
        write_pos(10'd100, 9'd50, 1'b0);
        present(10'd100, 9'd50, 12'h111);
        present(10'd101, 9'd50, 12'h222);
        checks++;
        if (color !== 12'h111) begin
            failures++;
            $display("FAIL pending_not_active_color: got %h want 111", color);
        end
        checks++;
        if (rom_addr !== 11'h000) begin
            failures++;
            $display("FAIL pending_not_active_addr: got %h want 000", rom_addr);
        end
        present(10'd0, 9'd0, 12'h000);
        present(10'd131, 9'd81, 12'h999);
        checks++;
        if (rom_addr !== 11'h3FF) begin
            failures++;
            $display("FAIL addr_bottom_right: got %h want 3FF", rom_addr);
        end
        present(10'd100, 9'd50, 12'hAAA);
        checks++;
        if (rom_addr !== 11'h000) begin
            failures++;
            $display("FAIL addr_top_left: got %h want 000", rom_addr);
        end
        checks++;
        if (color !== 12'h3FF) begin
            failures++;
            $display("FAIL color_bottom_right: got %h want 3FF", color);
        end
        present(10'd132, 9'd50, 12'h5A5);
        checks++;
        if (color !== 12'h000) begin
            failures++;
            $display("FAIL color_top_left: got %h want 000", color);
        end
        checks++;
        if (rom_addr !== 11'h000) begin
            failures++;
            $display("FAIL addr_hold_right_miss: got %h want 000", rom_addr);
        end
        present(10'd300, 9'd300, 12'h000);
        checks++;
        if (color !== 12'h5A5) begin
            failures++;
            $display("FAIL right_miss_bg: got %h want 5A5", color);
        end
    endtask

    task automatic test_transparency_mirror();
        rom_force = 1'b1; rom_force_val = 12'hF0F;
        present(10'd110, 9'd60, 12'h0F0);
        checks++;
        if (rom_addr !== 11'h14A) begin
            failures++;
            $display("FAIL addr_inside: got %h want 14A", rom_addr);
        end
        present(10'd111, 9'd60, 12'h0F0);
        checks++;
        if (color !== 12'h0F0) begin
            failures++;
            $display("FAIL key_transparent: got %h want 0F0", color);
        end
        rom_force_val = 12'h123;
        present(10'd112, 9'd60, 12'h0F0);
        checks++;
        if (color !== 12'h123) begin
            failures++;
            $display("FAIL opaque_pixel: got %h want 123", color);
        end
        rom_force = 1'b0;
        write_pos(10'd100, 9'd50, 1'b1);
        present(10'd0, 9'd0, 12'h000);
        present(10'd100, 9'd50, 12'h000);
        checks++;
        if (rom_addr !== 11'h01F) begin
            failures++;
            $display("FAIL mirror_col31: got %h want 01F", rom_addr);
        end
        present(10'd105, 9'd52, 12'h000);
        checks++;
        if (rom_addr !== 11'h05A) begin
            failures++;
            $display("FAIL mirror_col26_row2: got %h want 05A", rom_addr);
        end
        write_pos(10'd100, 9'd50, 1'b0);
    endtask

    task automatic test_coincident_write();
        // Frame start and a new write in the same clock; earlier pending is (100,50)
        @(negedge clk);
        x = 10'd0; y = 9'd0; bg_color = 12'h000; pix_ce = 1'b1;
        obj_x = 10'd200; obj_y = 9'd10; obj_mirror = 1'b0; pos_wr = 1'b1;
        @(negedge clk);
        pix_ce = 1'b0; pos_wr = 1'b0;
        repeat (2) @(negedge clk);
        present(10'd100, 9'd50, 12'h000);
        checks++;
        if (rom_addr !== 11'h000) begin
            failures++;
            $display("FAIL coincident_old_pos: got %h want 000", rom_addr);
        end
        present(10'd203, 9'd12, 12'h000);
        checks++;
        if (rom_addr !== 11'h000) begin
            failures++;
            $display("FAIL coincident_new_not_yet: got %h want 000", rom_addr);
        end
        present(10'd0, 9'd0, 12'h000);
        present(10'd203, 9'd12, 12'h000);
        checks++;
        if (rom_addr !== 11'h043) begin
            failures++;
            $display("FAIL coincident_new_next_frame: got %h want 043", rom_addr);
        end
        present(10'd100, 9'd50, 12'hBBB);
        checks++;
        if (rom_addr !== 11'h043) begin
            failures++;
            $display("FAIL old_pos_gone_addr: got %h want 043", rom_addr);
        end
        present(10'd300, 9'd300, 12'h000);
        checks++;
        if (color !== 12'hBBB) begin
            failures++;
            $display("FAIL old_pos_gone_color: got %h want BBB", color);
        end
    endtask

    task automatic test_animation();
        int   t0;
        logic exp_sel;
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        write_pos(10'd100, 9'd50, 1'b0);
        t0 = tick_cnt;
        for (int f = 0; f <= 16; f++) begin
            if (f >= 1) begin
                present(10'd100, 9'd50, 12'h000);
                exp_sel = ((f / 8) % 2) == 1;
                checks++;
                if (rom_addr[10] !== exp_sel) begin
                    failures++;
                    $display("FAIL anim_sel_frame%0d: got %b want %b", f, rom_addr[10], exp_sel);
                end
            end
            present(10'd0, 9'd0, 12'h000);
        end
        checks++;
        if (tick_cnt - t0 !== 17) begin
            failures++;
            $display("FAIL frame_tick_count: got %0d want 17", tick_cnt - t0);
        end
    endtask

    task automatic test_edge_clip();
        write_pos(10'd620, 9'd100, 1'b0);
        present(10'd0, 9'd0, 12'h000);
        present(10'd639, 9'd100, 12'h000);
        checks++;
        if (rom_addr !== 11'h013) begin
            failures++;
            $display("FAIL clip_last_col_addr: got %h want 013", rom_addr);
        end
        present(10'd619, 9'd100, 12'hCCC);
        checks++;
        if (rom_addr !== 11'h013) begin
            failures++;
            $display("FAIL clip_left_miss_addr: got %h want 013", rom_addr);
        end
        checks++;
        if (color !== 12'h013) begin
            failures++;
            $display("FAIL clip_last_col_color: got %h want 013", color);
        end
        present(10'd620, 9'd100, 12'hEEE);
        checks++;
        if (rom_addr !== 11'h000) begin
            failures++;
            $display("FAIL clip_first_col_addr: got %h want 000", rom_addr);
        end
        checks++;
        if (color !== 12'hCCC) begin
            failures++;
            $display("FAIL clip_left_miss_color: got %h want CCC", color);
        end
        present(10'd640, 9'd100, 12'hDDD);
        checks++;
        if (color !== 12'h000) begin
            failures++;
            $display("FAIL clip_first_col_color: got %h want 000", color);
        end
        present(10'd5, 9'd101, 12'hABC);
        checks++;
        if (color !== 12'h000 || color_valid !== 1'b0) begin
            failures++;
            $display("FAIL hblank: color=%h valid=%b want 000/0", color, color_valid);
        end
        present(10'd300, 9'd300, 12'h000);
        checks++;
        if (color !== 12'hABC || color_valid !== 1'b1) begin
            failures++;
            $display("FAIL no_wrap_next_line: color=%h valid=%b want ABC/1", color, color_valid);
        end
        // Sprite hanging off the right and bottom must not reappear near 0,0
        write_pos(10'd1010, 9'd500, 1'b0);
        present(10'd0, 9'd0, 12'h000);
        present(10'd5, 9'd5, 12'h777);
        checks++;
        if (rom_addr !== 11'h014) begin
            failures++;
            $display("FAIL wrap_addr_hold: got %h want 014", rom_addr);
        end
        present(10'd10, 9'd480, 12'hFFF);
        checks++;
        if (color !== 12'h777) begin
            failures++;
            $display("FAIL wrap_color_bg: got %h want 777", color);
        end
        present(10'd300, 9'd300, 12'h000);
        checks++;
        if (color !== 12'h000 || color_valid !== 1'b0) begin
            failures++;
            $display("FAIL vblank: color=%h valid=%b want 000/0", color, color_valid);
        end
    endtask

    initial begin
        test_reset();
        test_frame_aligned();
        test_transparency_mirror();
        test_coincident_write();
        test_animation();
        test_edge_clip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Per-pixel colour stage between the VGA scan counter (x, y) and the VGA data mux.
- Overlays one 32x32 animated, optionally mirrored sprite on a supplied background colour.
- Sprite pixels come from an external synchronous-read sprite ROM; one colour is a transparency key.
- Sprite position updates only at frame boundaries, so the sprite never tears.

Parameters:
- SPR_W, 32, sprite width in pixels (power of 2).
- SPR_H, 32, sprite height in pixels (power of 2).
- KEY, 12'hF0F, transparent colour code in ROM data.
- ANIM_DIV, 8, frames per animation-phase toggle (>=1).
- H_ACT, 640, active pixels per line.
- V_ACT, 480, active lines per frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- pix_ce  in  1  one-clk pulse per pixel; all pipeline state advances only when high.
- x  in  10  current scan column.
- y  in  9  current scan row.
- bg_color  in  12  background RGB444 for the current x,y.
- obj_x  in  10  requested sprite left column.
- obj_y  in  9  requested sprite top row.
- obj_mirror  in  1  requested horizontal mirror.
- pos_wr  in  1  one-clk strobe; captures obj_x, obj_y, obj_mirror into pending.
- rom_addr  out  11  {anim_sel, row[4:0], col[4:0]}.
- rom_data  in  12  ROM word; valid one clk after rom_addr changes.
- color  out  12  composited RGB444.
- color_valid  out  1  color corresponds to an active pixel.
- frame_tick  out  1  one-clk pulse at frame start.

Behaviour:
- Reset (rst=0, async): color=0, color_valid=0, rom_addr=0, frame_tick=0, anim_sel=0, anim_cnt=0, pend_flag=0. Active position act_x=10'h3FF, act_y=0, act_mirror=0, so nothing hits. Pending registers are 0. Reset mid-frame: the pipeline restarts; the first valid output comes 2 pix_ce after release.
- pos_wr (any clk): pend_x/pend_y/pend_mirror are loaded and pend_flag=1. The last write before frame start wins.
- Frame start: pix_ce with x==0 && y==0.
  - frame_tick=1 for that clk.
  - If pend_flag, act_* take pend_* and pend_flag clears.
  - If pos_wr fires in the same clk, pending takes the new value and pend_flag stays 1; act takes the old pending. The new value applies next frame.
  - anim_cnt increments; at ANIM_DIV-1 it wraps to 0 and anim_sel toggles.
- Hit test, combinational from registered act_*:
  - Condition: act_x <= x < act_x+SPR_W and act_y <= y < act_y+SPR_H.
  - Sums use 11-bit/10-bit widths, so there is no wrap. A sprite past the right or bottom edge is clipped and never reappears at x or y near 0.
- Address: col = x-act_x and row = y-act_y (low 5 bits). If act_mirror, col = SPR_W-1-col.
- Stage 1, on pix_ce:
  - rom_addr <= {anim_sel,row,col} on hit, else it holds its value.
  - Registers hit1, bg1=bg_color, act1=(x<H_ACT && y<V_ACT).
- Stage 2, on pix_ce, sampling rom_data:
  - color <= !act1 ? 0 : (hit1 && rom_data!=KEY) ? rom_data : bg1.
  - color_valid <= act1.
- Latency: exactly 2 pix_ce from x,y presentation to color. Between pix_ce pulses all outputs hold.
- pix_ce stuck low: everything freezes except pos_wr capture.

Test Plan:
- Reset: assert rst=0 mid-line -> color=0, color_valid=0, rom_addr=0. Release, present (5,5) -> color=bg_color after 2 pix_ce.
- Frame-aligned position: pos_wr (100,50) mid-frame -> bg-only output for the rest of the frame. Next frame: pixel (100,50) gives rom_addr=11'h000; (131,81) gives 11'h3FF; (132,50) outputs bg.
- Transparency and mirror:
  - Inside sprite, rom_data=F0F, bg=0F0 -> color=0F0.
  - rom_data=123 -> color=123.
  - obj_mirror=1 at pixel (100,50) -> rom_addr col field=31.
- Animation: ANIM_DIV=8 -> rom_addr[10]=0 for frames 0-7, 1 for frames 8-15, 0 again at frame 16. frame_tick pulses once per frame.
- Coincident write: pos_wr (200,10) in the same clk as frame start, with an earlier pending (100,50) -> this frame uses (100,50), next frame (200,10).
- Edge clipping: obj_x=620 -> hits on x=620..639 only; x=0..11 of the next line shows bg. Blanking (x>=640) -> color=0, color_valid=0.
